rect_fetch_seq: RTL and testbench



---
 rtl/rect_fetch_seq.sv | 148 ++++++++++++++
 tb/tb_rect_fetch_seq.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fetch_seq.sv
// Rectangle fetch sequencer: reads 4 ROM words per feature for a run of features
// and presents each packed rectangle (x, y, w, h) on a valid/ready stream.
module rect_fetch_seq #(
   parameter int W_DATA = 5,
   parameter int W_ADDR = 14,
   parameter int W_CNT  = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_valid,
   output logic                start_ready,
   input  logic [W_ADDR-3:0]   start_feat,
   input  logic [W_CNT-1:0]    num_feat,
   output logic                rom_en,
   output logic [W_ADDR-1:0]   rom_addr,
   input  logic [W_DATA-1:0]   rom_data,
   output logic                rect_valid,
   input  logic                rect_ready,
   output logic [W_DATA-1:0]   rect_x,
   output logic [W_DATA-1:0]   rect_y,
   output logic [W_DATA-1:0]   rect_w,
   output logic [W_DATA-1:0]   rect_h,
   output logic                rect_last,
   output logic                done,
   output logic [1:0]          o_dbg_state
);

   localparam int W_FEAT = W_ADDR - 2;

   // Handshakes: a transfer happens on a rising clk edge where valid && ready;
   // valid-side payload holds stable until that edge, ready may toggle freely.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [1:0]          r_k;
   logic [W_FEAT-1:0]   r_feat;
   logic [W_CNT-1:0]    r_rem;
   logic                r_cap_vld;
   logic [1:0]          r_cap_k;
   logic [W_DATA-1:0]   r_x;
   logic [W_DATA-1:0]   r_y;
   logic [W_DATA-1:0]   r_w;
   logic [W_DATA-1:0]   r_h;
   logic                r_done;
   logic                w_start;
   logic                w_last_rem;

   assign w_start    = start_valid && start_ready;
   assign w_last_rem = (r_rem == W_CNT'(1));

   always_comb begin
      w_next      = r_state;
      start_ready = 1'b0;
      rom_en      = 1'b0;
      rom_addr    = '0;
      rect_valid  = 1'b0;
      rect_last   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Held low while rst is asserted so no request is taken mid-reset.
            start_ready = !rst;
            if (w_start && (num_feat != '0))
               w_next = S_FETCH;
         end
         S_FETCH: begin
            rom_en   = 1'b1;
            rom_addr = {r_feat, r_k};
            if (r_k == 2'd3)
               w_next = S_DRAIN;
         end
         S_DRAIN: w_next = S_OUT;
         S_OUT: begin
            rect_valid = 1'b1;
            rect_last  = w_last_rem;
            if (rect_ready)
               w_next = w_last_rem ? S_IDLE : S_FETCH;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_k       <= 2'd0;
         r_feat    <= '0;
         r_rem     <= '0;
         r_cap_vld <= 1'b0;
         r_cap_k   <= 2'd0;
         r_x       <= '0;
         r_y       <= '0;
         r_w       <= '0;
         r_h       <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_done    <= 1'b0;
         // ROM answers one cycle after the read, so the word index is delayed too.
         r_cap_vld <= (r_state == S_FETCH);
         r_cap_k   <= r_k;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_feat <= start_feat;
                  r_rem  <= num_feat;
                  r_k    <= 2'd0;
                  if (num_feat == '0)
                     r_done <= 1'b1;
               end
            end
            S_FETCH: r_k <= r_k + 2'd1;
            S_OUT: begin
               if (rect_ready) begin
                  if (w_last_rem) begin
                     r_done <= 1'b1;
                  end else begin
                     r_feat <= r_feat + W_FEAT'(1);
                     r_rem  <= r_rem - W_CNT'(1);
                  end
               end
            end
            default: ;
         endcase
         if (r_cap_vld) begin
            case (r_cap_k)
               2'd0:    r_x <= rom_data;
               2'd1:    r_y <= rom_data;
               2'd2:    r_w <= rom_data;
               default: r_h <= rom_data;
            endcase
         end
      end
   end

   assign rect_x      = r_x;
   assign rect_y      = r_y;
   assign rect_w      = r_w;
   assign rect_h      = r_h;
   assign done        = r_done;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rect_fetch_seq.sv
// Bench for rect_fetch_seq: ROM model, address/rectangle scoreboard built from
// a run-level model, and one task per scenario with its own inline checks.
module tb_rect_fetch_seq;
  logic        clk;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [11:0] start_feat;
  logic [11:0] num_feat;
  logic        rom_en;
  logic [13:0] rom_addr;
  logic [4:0]  rom_data;
  logic        rect_valid;
  logic        rect_ready;
  logic [4:0]  rect_x, rect_y, rect_w, rect_h;
  logic        rect_last;
  logic        done;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int rom_cnt = 0;
  int rect_cnt = 0;
  int done_cnt = 0;

  logic [4:0]  mem [0:16383];
  logic [13:0] exp_addr_q[$];
  logic [20:0] exp_rect_q[$];

  rect_fetch_seq #(.W_DATA(5), .W_ADDR(14), .W_CNT(12)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_feat(start_feat), .num_feat(num_feat),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .rect_valid(rect_valid), .rect_ready(rect_ready),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .rect_last(rect_last), .done(done), .o_dbg_state(dbg_state)
  );

  // clock / ROM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial rom_data = 5'd0;
  always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

  // run-level model: a run is n features from f, each reading 4 words
  task automatic build_expect(input int f, input int n);
    for (int i = 0; i < n; i++) begin
      int idx;
      logic [13:0] a;
      idx = (f + i) % 4096;
      for (int k = 0; k < 4; k++) begin
        a = 14'(idx * 4 + k);
        exp_addr_q.push_back(a);
      end
      a = 14'(idx * 4);
      exp_rect_q.push_back({mem[a], mem[a + 14'd1], mem[a + 14'd2], mem[a + 14'd3], (i == n - 1)});
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (rom_en) begin
        rom_cnt++;
        total++;
        if (exp_addr_q.size() == 0) begin
          bad++;
          $display("FAIL rom_addr unexpected read got=%0d exp=none", rom_addr);
        end else begin
          if (rom_addr !== exp_addr_q[0]) begin
            bad++;
            $display("FAIL rom_addr got=%0d exp=%0d", rom_addr, exp_addr_q[0]);
          end
          void'(exp_addr_q.pop_front());
        end
      end
      if (rect_valid && rect_ready) begin
        rect_cnt++;
        total++;
        if (exp_rect_q.size() == 0) begin
          bad++;
          $display("FAIL rect unexpected got=%h exp=none", {rect_x, rect_y, rect_w, rect_h, rect_last});
        end else begin
          if ({rect_x, rect_y, rect_w, rect_h, rect_last} !== exp_rect_q[0]) begin
            bad++;
            $display("FAIL rect got=%h exp=%h", {rect_x, rect_y, rect_w, rect_h, rect_last}, exp_rect_q[0]);
          end
          void'(exp_rect_q.pop_front());
        end
      end
      if (done) done_cnt++;
    end
  end

  // driver tasks
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int f, input int n, input bit hold);
    build_expect(f, n);
    start_feat  = 12'(f);
    num_feat    = 12'(n);
    start_valid = 1'b1;
    next_cyc();
    if (!hold) start_valid = 1'b0;
  endtask

  task automatic run_until_done(input int bound, input bit rand_ready, output int cyc);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (done || cyc >= bound) break;
      next_cyc();
      if (rand_ready) rect_ready = 1'($urandom_range(0, 1));
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL done_timeout got=no_done exp=done_within_%0d", bound);
    end
    next_cyc();
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    next_cyc();
    next_cyc();
    @(negedge clk);
    total++;
    if ({start_ready, rom_en, rom_addr, rect_valid, rect_last, done} !== 19'd0 ||
        {rect_x, rect_y, rect_w, rect_h} !== 20'd0) begin
      bad++;
      $display("FAIL reset_values got=%b_%b_%0d_%b_%b_%b_%h exp=all_zero", start_ready, rom_en,
               rom_addr, rect_valid, rect_last, done, {rect_x, rect_y, rect_w, rect_h});
    end
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (start_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_ready_after_reset got=%b exp=1", start_ready);
    end
    next_cyc();
  endtask

  task automatic test_single();
    rect_ready = 1'b1;
    do_start(0, 1, 0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      total++;
      if (rom_en !== (c <= 4) || rect_valid !== (c == 6) || done !== (c == 7) ||
          start_ready !== (c >= 7) || rect_last !== (c == 6)) begin
        bad++;
        $display("FAIL single_timing cycle=%0d got en=%b v=%b d=%b sr=%b l=%b exp en=%b v=%b d=%b sr=%b l=%b",
                 c, rom_en, rect_valid, done, start_ready, rect_last,
                 c <= 4, c == 6, c == 7, c >= 7, c == 6);
      end
      if (c <= 4) begin
        total++;
        if (rom_addr !== 14'(c - 1)) begin
          bad++;
          $display("FAIL single_addr cycle=%0d got=%0d exp=%0d", c, rom_addr, c - 1);
        end
      end
      if (c == 6) begin
        total++;
        if ({rect_x, rect_y, rect_w, rect_h} !== {5'h06, 5'h07, 5'h0c, 5'h03}) begin
          bad++;
          $display("FAIL single_fields got=%h,%h,%h,%h exp=06,07,0c,03", rect_x, rect_y, rect_w, rect_h);
        end
      end
      next_cyc();
    end
  endtask

  task automatic test_run3();
    int r0, q0, d0, cyc;
    r0 = rom_cnt; q0 = rect_cnt; d0 = done_cnt;
    rect_ready = 1'b1;
    do_start(1, 3, 0);
    run_until_done(40, 0, cyc);
    total++;
    if (cyc !== 19) begin
      bad++;
      $display("FAIL run3_latency got=%0d exp=19", cyc);
    end
    total++;
    if (rom_cnt - r0 !== 12 || rect_cnt - q0 !== 3 || done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL run3_counts got=%0d/%0d/%0d exp=12/3/1", rom_cnt - r0, rect_cnt - q0, done_cnt - d0);
    end
  endtask

  task automatic test_backpressure();
    int f, cyc;
    logic [13:0] a;
    f = $urandom_range(0, 4094);
    a = 14'(f * 4);
    rect_ready = 1'b0;
    do_start(f, 2, 0);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (rect_valid || cyc >= 20) break;
      next_cyc();
    end
    total++;
    if (cyc !== 6) begin
      bad++;
      $display("FAIL bp_first_valid got=%0d exp=6", cyc);
    end
    for (int s = 0; s < 5; s++) begin
      if (s > 0) begin
        next_cyc();
        @(negedge clk);
      end
      total++;
      if (rect_valid !== 1'b1 || rom_en !== 1'b0 || rect_last !== 1'b0 ||
          {rect_x, rect_y, rect_w, rect_h} !== {mem[a], mem[a + 14'd1], mem[a + 14'd2], mem[a + 14'd3]}) begin
        bad++;
        $display("FAIL bp_stall s=%0d got v=%b en=%b l=%b f=%h exp v=1 en=0 l=0 f=%h", s, rect_valid, rom_en,
                 rect_last, {rect_x, rect_y, rect_w, rect_h},
                 {mem[a], mem[a + 14'd1], mem[a + 14'd2], mem[a + 14'd3]});
      end
    end
    next_cyc();
    rect_ready = 1'b1;
    @(negedge clk);
    next_cyc();
    @(negedge clk);
    total++;
    if (rom_en !== 1'b1 || rom_addr !== 14'(((f + 1) % 4096) * 4)) begin
      bad++;
      $display("FAIL bp_refetch got en=%b addr=%0d exp en=1 addr=%0d", rom_en, rom_addr, ((f + 1) % 4096) * 4);
    end
    next_cyc();
    run_until_done(40, 0, cyc);
  endtask

  task automatic test_zero();
    int r0;
    r0 = rom_cnt;
    do_start($urandom_range(0, 4095), 0, 0);
    @(negedge clk);
    total++;
    if (done !== 1'b1 || start_ready !== 1'b1 || rect_valid !== 1'b0 || rom_en !== 1'b0) begin
      bad++;
      $display("FAIL zero_pulse got d=%b sr=%b v=%b en=%b exp d=1 sr=1 v=0 en=0", done, start_ready, rect_valid, rom_en);
    end
    next_cyc();
    @(negedge clk);
    total++;
    if (done !== 1'b0 || start_ready !== 1'b1 || rom_cnt !== r0) begin
      bad++;
      $display("FAIL zero_after got d=%b sr=%b reads=%0d exp d=0 sr=1 reads=0", done, start_ready, rom_cnt - r0);
    end
    next_cyc();
  endtask

  task automatic test_busy_wrap();
    int r0, q0, d0;
    r0 = rom_cnt; q0 = rect_cnt; d0 = done_cnt;
    rect_ready = 1'b1;
    do_start(4095, 2, 1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      total++;
      if (start_ready !== 1'b0) begin
        bad++;
        $display("FAIL busy_start_ready cycle=%0d got=%b exp=0", c, start_ready);
      end
      next_cyc();
    end
    start_valid = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL wrap_done got=%b exp=1", done);
    end
    repeat (10) next_cyc();
    total++;
    if (rom_cnt - r0 !== 8 || rect_cnt - q0 !== 2 || done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL busy_counts got=%0d/%0d/%0d exp=8/2/1", rom_cnt - r0, rect_cnt - q0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int d0, cyc;
    rect_ready = 1'b1;
    do_start($urandom_range(0, 4095), 3, 0);
    next_cyc();
    next_cyc();
    rst = 1'b1;
    @(negedge clk);
    next_cyc();
    @(negedge clk);
    total++;
    if (rom_en !== 1'b0 || rect_valid !== 1'b0 || done !== 1'b0 || start_ready !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs got en=%b v=%b d=%b sr=%b exp 0,0,0,0", rom_en, rect_valid, done, start_ready);
    end
    exp_addr_q.delete();
    exp_rect_q.delete();
    d0 = done_cnt;
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (start_ready !== 1'b1 || done !== 1'b0 || rom_en !== 1'b0) begin
      bad++;
      $display("FAIL midreset_release got sr=%b d=%b en=%b exp sr=1 d=0 en=0", start_ready, done, rom_en);
    end
    next_cyc();
    do_start($urandom_range(0, 4095), 2, 0);
    run_until_done(40, 0, cyc);
    total++;
    if (cyc !== 13 || done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL midreset_rerun got cyc=%0d dones=%0d exp cyc=13 dones=1", cyc, done_cnt - d0);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int n, r0, q0, d0, cyc;
      n = $urandom_range(1, 5);
      r0 = rom_cnt; q0 = rect_cnt; d0 = done_cnt;
      rect_ready = 1'($urandom_range(0, 1));
      do_start($urandom_range(0, 4095), n, 0);
      run_until_done(300, 1, cyc);
      total++;
      if (rom_cnt - r0 !== 4 * n || rect_cnt - q0 !== n || done_cnt - d0 !== 1) begin
        bad++;
        $display("FAIL random_counts run=%0d got=%0d/%0d/%0d exp=%0d/%0d/1", r, rom_cnt - r0,
                 rect_cnt - q0, done_cnt - d0, 4 * n, n);
      end
    end
  endtask

  initial begin
    logic [4:0] fixed [0:15];
    fixed = '{5'h06, 5'h07, 5'h0c, 5'h03, 5'h0a, 5'h04, 5'h04, 5'h07,
              5'h03, 5'h0c, 5'h12, 5'h03, 5'h08, 5'h14, 5'h09, 5'h02};
    for (int i = 0; i < 16384; i++) mem[i] = 5'($urandom_range(0, 31));
    for (int i = 0; i < 16; i++) mem[i] = fixed[i];
    rst = 1'b1;
    start_valid = 1'b0;
    start_feat = '0;
    num_feat = '0;
    rect_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_run3();
    test_backpressure();
    test_zero();
    test_busy_wrap();
    test_reset_mid();
    test_random();
    total++;
    if (exp_addr_q.size() != 0 || exp_rect_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expect got=%0d/%0d exp=0/0", exp_addr_q.size(), exp_rect_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
